// File: rtl/triangle_scheduler.sv
// Two-way round-robin front end for the triangle rasteriser: grants one
// requester, holds its triangle stable, pulses draw_en and waits for draw_done.
module triangle_scheduler #(
    parameter int WIDTH        = 8,
    parameter int COLOUR_WIDTH = 3
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic [1:0]                             req_valid,
    input  logic [2*(6*WIDTH+COLOUR_WIDTH)-1:0]    req_tri,
    output logic [1:0]                             req_ready,
    output logic [1:0]                             req_done,
    output logic [WIDTH-1:0]                       ax,
    output logic [WIDTH-1:0]                       ay,
    output logic [WIDTH-1:0]                       bx,
    output logic [WIDTH-1:0]                       by,
    output logic [WIDTH-1:0]                       cx,
    output logic [WIDTH-1:0]                       cy,
    output logic [COLOUR_WIDTH-1:0]                colour,
    output logic                                   draw_en,
    input  logic                                   draw_done,
    output logic                                   busy,
    output logic [15:0]                            tri_count
);

    localparam int TRI_W = 6*WIDTH + COLOUR_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT
    } state_t;

    state_t             state_q, state_d;
    logic               last_grant_q, last_grant_d;
    logic               owner_q, owner_d;
    logic [TRI_W-1:0]   tri_q, tri_d;
    logic [1:0]         req_done_q, req_done_d;
    logic [15:0]        tri_count_q, tri_count_d;
    logic [1:0]         grant;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            tri_q        <= '0;
            req_done_q   <= 2'b00;
            tri_count_q  <= 16'd0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            tri_q        <= tri_d;
            req_done_q   <= req_done_d;
            tri_count_q  <= tri_count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        tri_d        = tri_q;
        req_done_d   = 2'b00;
        tri_count_d  = tri_count_q;
        grant        = 2'b00;
        case (state_q)
            S_IDLE: begin
                // On a tie the requester that did not win last time goes next.
                if (req_valid == 2'b11) begin
                    grant = last_grant_q ? 2'b01 : 2'b10;
                end else begin
                    grant = req_valid;
                end
                if (grant != 2'b00) begin
                    owner_d      = grant[1];
                    last_grant_d = grant[1];
                    tri_d        = grant[1] ? req_tri[TRI_W +: TRI_W] : req_tri[0 +: TRI_W];
                    state_d      = S_START;
                end
            end
            S_START: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (draw_done) begin
                    state_d             = S_IDLE;
                    req_done_d[owner_q] = 1'b1;
                    tri_count_d         = tri_count_q + 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign req_ready = reset ? grant : 2'b00;
    assign {colour, cy, cx, by, bx, ay, ax} = tri_q;
    assign draw_en   = (state_q == S_START);
    assign busy      = (state_q != S_IDLE);
    assign req_done  = req_done_q;
    assign tri_count = tri_count_q;

endmodule

// File: doc/triangle_scheduler.md
# triangle_scheduler

Sequencer and two-way round-robin arbiter in front of the triangle rasteriser (`draw_triangle`). It accepts triangle commands from two requesters, for example the scene renderer on port 0 and the HUD/overlay on port 1. It holds the granted triangle stable on the rasteriser inputs, issues a single-cycle `draw_en`, and waits for `draw_done` before granting again. Completions are reported per requester, and a running triangle count is kept for frame statistics.

## Interface
Parameters:
- `WIDTH`, 8, coordinate width; matches the rasteriser.
- `COLOUR_WIDTH`, 3, colour width; matches the rasteriser.
- Derived `TRI_W` = 6*WIDTH + COLOUR_WIDTH. This is a localparam, not overridable.

Ports:
- `clock`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  2  bit i: requester i presents a triangle.
- `req_tri`  in  2*TRI_W  requester i at bits [i*TRI_W +: TRI_W].
  - Field order from LSB: ax, ay, bx, by, cx, cy, then colour in the top COLOUR_WIDTH bits.
- `req_ready`  out  2  bit i: triangle from requester i accepted this cycle.
- `req_done`  out  2  bit i: one-cycle pulse when requester i's triangle finishes.
- `ax, ay, bx, by, cx, cy`  out  WIDTH each  latched vertices to the rasteriser.
- `colour`  out  COLOUR_WIDTH  latched colour to the rasteriser.
- `draw_en`  out  1  one-cycle start pulse to the rasteriser.
- `draw_done`  in  1  rasteriser completion.
- `busy`  out  1  high from acceptance through the completion cycle.
- `tri_count`  out  16  number of triangles completed since reset; wraps.

## Operation
States:
- S_IDLE: may grant. Stays in S_IDLE while `req_valid` == 0.
- S_START: asserts `draw_en` for exactly one cycle, then always goes to S_WAIT.
- S_WAIT: holds until `draw_done` == 1, then returns to S_IDLE.

Arbitration (S_IDLE only):
- `last_grant` register, reset value 1, so requester 0 wins the first tie.
- If exactly one `req_valid` bit is set, that requester is granted.
- If both are set, the requester ≠ `last_grant` is granted.
- `req_ready` is combinational: one-hot grant while in S_IDLE with reset deasserted; 0 in every other state. At most one bit is ever high.
- A handshake is `req_valid[i] & req_ready[i]`. On the handshake:
  - latch req_tri slice i into the coordinate/colour output registers;
  - record `owner` = i;
  - set `last_grant` = i;
  - go to S_START.

Holding and completion:
- Output coordinates and colour are registered and change only on a handshake. They stay stable through S_START and S_WAIT and hold their last value in S_IDLE.
- `draw_done` is ignored in S_IDLE and S_START. It is sampled only in S_WAIT, which guarantees at least one cycle between `draw_en` and an accepted done.
- On `draw_done` in S_WAIT:
  - next cycle `req_done[owner]` = 1 for exactly one cycle;
  - `tri_count` increments by 1 (0xFFFF wraps to 0x0000);
  - state returns to S_IDLE.
- `busy` = (state ≠ S_IDLE). `req_done` is registered and is high in the first S_IDLE cycle after completion.
- A new grant may occur in that same first S_IDLE cycle. Back-to-back throughput is one triangle per (rasteriser time + 3) cycles.

## Timing
Reset values:
- state S_IDLE, `last_grant` 1, `owner` 0.
- all coordinates 0, `colour` 0.
- `draw_en` 0, `req_done` 00, `busy` 0, `tri_count` 0.
- `req_ready` 00 while reset is low, regardless of `req_valid`.

Latency:
- Handshake in cycle T: S_START and `draw_en`=1 in T+1, S_WAIT from T+2.
- `draw_done` in cycle D (≥ T+2): `req_done` pulse, S_IDLE and `busy`=0 in D+1, `tri_count` updated in D+1.

Boundary conditions:
- Requester drops `req_valid` without a handshake: no effect, no grant.
- `draw_done` held high continuously: each triangle completes in its first S_WAIT cycle. Minimum cycle is 3 clocks per triangle, and there are no double completions.
- Reset asserted mid-draw (S_START or S_WAIT): immediate return to reset values. The in-flight triangle is dropped and no `req_done` is issued.
- Requester changes `req_tri` after the handshake: outputs are unaffected.

## Test plan
- **Single request.** `req_valid`=01 with ax=10, ay=20, bx=30, by=5, cx=50, cy=40, colour=3.
  - `req_ready`=01 in T; `draw_en` only in T+1; outputs equal those values.
  - `draw_done` pulsed at T+5 → `req_done`=01 at T+6, `tri_count`=1, `busy`=0 at T+6.
- **Round-robin fairness.** Both valid continuously, `draw_done` tied high.
  - Grant order 0,1,0,1; a handshake every 3 cycles.
  - After 4 completions, `tri_count`=4 with two `req_done` pulses per requester.
- **Early done ignored.** Pulse `draw_done` in S_IDLE and in the S_START cycle.
  - No completion, `tri_count` unchanged.
  - Only a later `draw_done` in S_WAIT completes the triangle.
- **Reset mid-draw.** Assert `reset` low during S_WAIT.
  - All outputs at reset values, `req_ready`=00 while low, no `req_done`.
  - After release with `req_valid`=11, requester 0 is granted first.
- **Counter wrap.** Force 65,536 completions (or preload via a bench hierarchy force) → `tri_count` wraps 0xFFFF → 0x0000.
- **Input change after acceptance.** Change requester 1's `req_tri` during S_WAIT → `ax..colour` outputs hold the accepted values.
